// File: rtl/demux_1x4_16_buf_pkg.sv
// Shared constants and slot state encoding for the buffered 1-to-4 demux.
// Optional build macro used by the top: DEMUX_AUTOSEL_EN (round-robin channel select).
package demux_1x4_16_buf_pkg;

    localparam int NCH   = 4;
    localparam int SEL_W = 2;

    localparam logic [SEL_W-1:0] CH0 = 2'd0;
    localparam logic [SEL_W-1:0] CH1 = 2'd1;
    localparam logic [SEL_W-1:0] CH2 = 2'd2;
    localparam logic [SEL_W-1:0] CH3 = 2'd3;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } slot_state_t;

endpackage

// File: rtl/demux_1x4_16_buf_slot.sv
// One-entry output buffer: holds one word until its consumer takes it.
// Latency: word loaded at edge n is visible after edge n.
// Backpressure: drain and load in the same edge keeps the slot full (full throughput).
module demux_1x4_16_buf_slot
    import demux_1x4_16_buf_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_dat,
    input  logic             out_rdy,
    output logic [WIDTH-1:0] dat,
    output logic             vld
);

    slot_state_t state;
    slot_state_t state_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_EMPTY: if (load) state_nxt = ST_FULL;
            ST_FULL:  if (out_rdy && !load) state_nxt = ST_EMPTY;
            default:  state_nxt = ST_EMPTY;
        endcase
    end

    // Data is kept after a drain; only a load overwrites it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dat <= '0;
        end else if (load) begin
            dat <= load_dat;
        end
    end

    assign vld = (state == ST_FULL);

endmodule

// File: rtl/demux_1x4_16_buf.sv
// Buffered 1-to-4 demux: steers each accepted word into one of four one-entry buffers.
// Latency: one edge from accept to o<sel>/out_valid[sel]; DEMUX_AUTOSEL_EN adds round-robin select.
// Backpressure: in_ready drops only when the selected buffer is full and not being drained.
module demux_1x4_16_buf
    import demux_1x4_16_buf_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i,
    input  logic [SEL_W-1:0] s,
    input  logic             auto_mode,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] o0,
    output logic [WIDTH-1:0] o1,
    output logic [WIDTH-1:0] o2,
    output logic [WIDTH-1:0] o3,
    output logic [NCH-1:0]   out_valid,
    input  logic [NCH-1:0]   out_ready,
    output logic [CNT_W-1:0] acc_cnt
);

    logic [SEL_W-1:0] sel;
    logic             accept;
    logic [WIDTH-1:0] slot_dat [NCH];

`ifdef DEMUX_AUTOSEL_EN
    logic [SEL_W-1:0] rr_ptr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr <= CH0;
        end else if (accept && auto_mode) begin
            rr_ptr <= rr_ptr + SEL_W'(1);
        end
    end

    assign sel = auto_mode ? rr_ptr : s;
`else
    logic unused_auto_mode;
    assign unused_auto_mode = auto_mode;
    assign sel = s;
`endif

    assign in_ready = !rst && (!out_valid[sel] || out_ready[sel]);
    assign accept   = in_valid && in_ready;

    for (genvar k = 0; k < NCH; k++) begin : g_slot
        demux_1x4_16_buf_slot #(
            .WIDTH (WIDTH)
        ) u_slot (
            .clk      (clk),
            .rst      (rst),
            .load     (accept && (sel == SEL_W'(k))),
            .load_dat (i),
            .out_rdy  (out_ready[k]),
            .dat      (slot_dat[k]),
            .vld      (out_valid[k])
        );
    end

    assign o0 = slot_dat[CH0];
    assign o1 = slot_dat[CH1];
    assign o2 = slot_dat[CH2];
    assign o3 = slot_dat[CH3];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_cnt <= '0;
        end else if (accept) begin
            acc_cnt <= acc_cnt + CNT_W'(1);
        end
    end

endmodule
